// File: rtl/uart_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised UART FIFO.
package uart_fifo_param_pkg;

    localparam int MAX_DEPTH  = 256;
    localparam int MAX_DATA_W = 32;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_fifo_param_if.sv
// FIFO control/status bundle between the register block and the shifter.
interface uart_fifo_param_if
    import uart_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, data_in, rd_en, clr_err,
        input  data_out, rd_valid, full, empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, clr_err,
        output data_out, rd_valid, full, empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// DATA_W x DEPTH storage: one write port, one registered read port.
module uart_fifo_mem
    import uart_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array left unreset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO with thresholds, sticky errors and flush.
module uart_fifo_param
    import uart_fifo_param_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  DEPTH    = 32,
    parameter int  AF_LEVEL = 28,
    parameter int  AE_LEVEL = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             reset_n,
    uart_fifo_param_if.slave bus
);

    if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("uart_fifo_param: DEPTH must be a power of two in 2..256");
    end
    if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("uart_fifo_param: DATA_W must be in 1..32");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("uart_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("uart_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          empty;
    logic          rd_acc;
    logic          wr_acc;
    logic          ovf_set;
    logic          unf_set;
    logic          ovf;
    logic          unf;
    logic          rv;

    // Flags decode the registered count, never pointer equality.
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // Flush masks both requests so they neither move state nor raise errors.
    always_comb begin
        rd_acc  = ~bus.flush & bus.rd_en & ~empty;
        wr_acc  = ~bus.flush & bus.wr_en & (~full | rd_acc);
        ovf_set = ~bus.flush & bus.wr_en & ~wr_acc;
        unf_set = ~bus.flush & bus.rd_en & empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rv     <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rv     <= 1'b0;
        end else begin
            rv <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error in the same cycle as clr_err takes precedence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (bus.flush) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~bus.clr_err);
            unf <= unf_set | (unf & ~bus.clr_err);
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_acc),
        .waddr   (wr_ptr),
        .wdata   (bus.data_in),
        .re      (rd_acc),
        .raddr   (rd_ptr),
        .rdata   (bus.data_out)
    );

    assign bus.rd_valid     = rv;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt >= AF_CNT);
    assign bus.almost_empty = (cnt <= AE_CNT);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Self-checking bench: DEPTH=32/DATA_W=8 and DEPTH=4/DATA_W=12 instances.
module tb_uart_fifo_param;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    uart_fifo_param_if #(.DATA_W(8),  .DEPTH(32)) b32 ();
    uart_fifo_param_if #(.DATA_W(12), .DEPTH(4))  b4 ();

    uart_fifo_param #(
        .DATA_W(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4)
    ) u_dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b32)
    );

    uart_fifo_param #(
        .DATA_W(12), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b4)
    );

    typedef struct {
        int          cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        ovf;
        logic        unf;
        logic        rv;
        logic [31:0] dout;
    } obs_t;

    typedef struct {
        bit         w;
        logic [7:0] d;
        bit         r;
        bit         ce;
        int         e_cnt;
        bit         e_rv;
        logic [7:0] e_dout;
        bit         e_unf;
    } vec_t;

    int          dep  [2] = '{32, 4};
    int          afl  [2] = '{28, 3};
    int          ael  [2] = '{4, 1};
    logic [31:0] mask [2] = '{32'hFF, 32'hFFF};

    int          m_cnt  [2];
    bit          m_ovf  [2];
    bit          m_unf  [2];
    logic [31:0] m_dout [2];
    logic [31:0] mq0[$], mq1[$];
    logic [31:0] eq0[$], eq1[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic drive(input int u, input bit w, input logic [31:0] d,
                         input bit r, input bit f, input bit ce);
        b32.wr_en   = (u == 0) && w;
        b32.rd_en   = (u == 0) && r;
        b32.flush   = (u == 0) && f;
        b32.clr_err = (u == 0) && ce;
        b32.data_in = d[7:0];
        b4.wr_en    = (u == 1) && w;
        b4.rd_en    = (u == 1) && r;
        b4.flush    = (u == 1) && f;
        b4.clr_err  = (u == 1) && ce;
        b4.data_in  = d[11:0];
    endtask

    function automatic obs_t sample(input int u);
        obs_t o;
        if (u == 0) begin
            o.cnt  = int'(b32.count);
            o.full = b32.full;
            o.empty = b32.empty;
            o.af   = b32.almost_full;
            o.ae   = b32.almost_empty;
            o.ovf  = b32.overflow;
            o.unf  = b32.underflow;
            o.rv   = b32.rd_valid;
            o.dout = 32'(b32.data_out);
        end else begin
            o.cnt  = int'(b4.count);
            o.full = b4.full;
            o.empty = b4.empty;
            o.af   = b4.almost_full;
            o.ae   = b4.almost_empty;
            o.ovf  = b4.overflow;
            o.unf  = b4.underflow;
            o.rv   = b4.rd_valid;
            o.dout = 32'(b4.data_out);
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_cnt[u]  = 0;
            m_ovf[u]  = 1'b0;
            m_unf[u]  = 1'b0;
            m_dout[u] = '0;
        end
        mq0.delete(); mq1.delete();
        eq0.delete(); eq1.delete();
    endtask

    task automatic chk_reset(input int u);
        obs_t o;
        o = sample(u);
        chk("rst count", o.cnt, 0);
        chk("rst empty", o.empty, 1);
        chk("rst almost_empty", o.ae, 1);
        chk("rst full", o.full, 0);
        chk("rst almost_full", o.af, 0);
        chk("rst rd_valid", o.rv, 0);
        chk("rst data_out", o.dout, 0);
        chk("rst overflow", o.ovf, 0);
        chk("rst underflow", o.unf, 0);
    endtask

    // One clock of stimulus on unit u, checked against the model.
    task automatic cyc(input int u, input bit w, input logic [31:0] d,
                       input bit r, input bit f, input bit ce,
                       output bit wacc, output obs_t o);
        logic [31:0] dm;
        logic [31:0] v;
        bit racc;
        bit ovs;
        bit uns;
        dm = d & mask[u];
        drive(u, w, dm, r, f, ce);
        racc = !f && r && (m_cnt[u] > 0);
        wacc = !f && w && ((m_cnt[u] < dep[u]) || racc);
        ovs  = !f && w && !wacc;
        uns  = !f && r && (m_cnt[u] == 0);
        if (racc) begin
            if (u == 0) begin
                v = mq0.pop_front();
                eq0.push_back(v);
            end else begin
                v = mq1.pop_front();
                eq1.push_back(v);
            end
        end
        if (wacc) begin
            if (u == 0) mq0.push_back(dm);
            else        mq1.push_back(dm);
        end
        @(posedge clk);
        #1;
        if (f) begin
            if (u == 0) mq0.delete();
            else        mq1.delete();
            m_cnt[u] = 0;
            m_ovf[u] = 1'b0;
            m_unf[u] = 1'b0;
        end else begin
            m_cnt[u] = m_cnt[u] + int'(wacc) - int'(racc);
            m_ovf[u] = ovs ? 1'b1 : (ce ? 1'b0 : m_ovf[u]);
            m_unf[u] = uns ? 1'b1 : (ce ? 1'b0 : m_unf[u]);
        end
        o = sample(u);
        chk("count", o.cnt, m_cnt[u]);
        chk("full", o.full, m_cnt[u] == dep[u]);
        chk("empty", o.empty, m_cnt[u] == 0);
        chk("almost_full", o.af, m_cnt[u] >= afl[u]);
        chk("almost_empty", o.ae, m_cnt[u] <= ael[u]);
        chk("overflow", o.ovf, m_ovf[u]);
        chk("underflow", o.unf, m_unf[u]);
        chk("rd_valid", o.rv, racc);
        if (o.rv === 1'b1) begin
            if ((u == 0 ? eq0.size() : eq1.size()) == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_pop @%0t: got rd_valid=1 required no pending read",
                         $time);
            end else begin
                v = (u == 0) ? eq0.pop_front() : eq1.pop_front();
                m_dout[u] = v;
                chk("data_out", o.dout, v);
            end
        end else begin
            chk("data_out hold", o.dout, m_dout[u]);
        end
    endtask

    vec_t tbl[6];

    initial begin
        bit   wa;
        obs_t o;
        int   sent;
        int   got;
        int   ncyc;

        tbl[0] = '{w:0, d:8'h00, r:1, ce:0, e_cnt:0, e_rv:0, e_dout:8'hBB, e_unf:1};
        tbl[1] = '{w:1, d:8'h55, r:1, ce:0, e_cnt:1, e_rv:0, e_dout:8'hBB, e_unf:1};
        tbl[2] = '{w:0, d:8'h00, r:0, ce:1, e_cnt:1, e_rv:0, e_dout:8'hBB, e_unf:0};
        tbl[3] = '{w:0, d:8'h00, r:1, ce:0, e_cnt:0, e_rv:1, e_dout:8'h55, e_unf:0};
        tbl[4] = '{w:0, d:8'h00, r:1, ce:1, e_cnt:0, e_rv:0, e_dout:8'h55, e_unf:1};
        tbl[5] = '{w:0, d:8'h00, r:0, ce:1, e_cnt:0, e_rv:0, e_dout:8'h55, e_unf:0};

        drive(0, 0, 0, 0, 0, 0);
        b32.wr_en = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, i, 0, 0, 0, wa, o);
            if (i == 26) chk("af below 28", o.af, 0);
            if (i == 27) chk("af at 28", o.af, 1);
        end
        chk("full at 32", o.full, 1);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 1, 0, 0, wa, o);
            chk("ordered read", o.dout, i);
        end
        chk("empty after drain", o.empty, 1);

        for (int i = 0; i < 32; i++) cyc(0, 1, i, 0, 0, 0, wa, o);
        cyc(0, 1, 32'hAA, 0, 0, 0, wa, o);
        chk("ovf on full", o.ovf, 1);
        chk("count held 32", o.cnt, 32);
        cyc(0, 1, 32'hBB, 1, 0, 0, wa, o);
        chk("full wr+rd count", o.cnt, 32);
        chk("full wr+rd data", o.dout, 32'h00);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 1, 0, 0, wa, o);
        chk("last word BB", o.dout, 32'hBB);
        cyc(0, 0, 0, 0, 0, 1, wa, o);
        chk("clr ovf", o.ovf, 0);

        for (int i = 0; i < 6; i++) begin
            cyc(0, tbl[i].w, 32'(tbl[i].d), tbl[i].r, 0, tbl[i].ce, wa, o);
            chk($sformatf("tbl%0d count", i), o.cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d rd_valid", i), o.rv, tbl[i].e_rv);
            chk($sformatf("tbl%0d data_out", i), o.dout, 32'(tbl[i].e_dout));
            chk($sformatf("tbl%0d underflow", i), o.unf, tbl[i].e_unf);
        end

        cyc(0, 0, 0, 1, 0, 0, wa, o);
        for (int i = 0; i < 10; i++) cyc(0, 1, 32'h40 + i, 0, 0, 0, wa, o);
        chk("count 10", o.cnt, 10);
        cyc(0, 1, 32'hEE, 0, 1, 0, wa, o);
        chk("flush count", o.cnt, 0);
        chk("flush empty", o.empty, 1);
        chk("flush ovf", o.ovf, 0);
        chk("flush unf", o.unf, 0);

        cyc(0, 0, 0, 1, 0, 0, wa, o);
        for (int i = 0; i < 6; i++) cyc(0, 1, 32'h61 + i, 0, 0, 0, wa, o);
        cyc(0, 0, 0, 1, 0, 0, wa, o);
        chk("pre-reset count", o.cnt, 5);
        drive(0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk_reset(0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 1, 32'h77, 0, 0, 0, wa, o);
        cyc(0, 0, 0, 1, 0, 0, wa, o);
        chk("post-reset read", o.dout, 32'h77);

        sent = 0;
        got  = 0;
        ncyc = 0;
        while ((sent < 100 || m_cnt[1] > 0) && ncyc < 3000) begin
            cyc(1, (sent < 100) && ($urandom_range(0, 3) != 0),
                32'h300 + sent, $urandom_range(0, 2) != 0, 0, 0, wa, o);
            if (wa) sent++;
            if (o.rv === 1'b1) got++;
            if (o.cnt > 4) chk("d4 count range", o.cnt, 4);
            ncyc++;
        end
        chk("d4 stream bounded", ncyc < 3000, 1);
        chk("d4 words read", got, 100);
        chk("scoreboard drained", eq0.size() + eq1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
